// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state type and default operand width for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int SUB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub1.sv
// full_sub1: combinational 1-bit full subtractor.
//   x, y, bi : minuend bit, subtrahend bit, borrow in
//   d, bo    : difference bit, borrow out
module full_sub1 (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub8.sv
// serial_sub8: bit-serial a - b - bin, LSB first, one bit per clock, start/busy/done framed.
//   clk, rst          : clock, asynchronous active-high reset
//   start, a, b, bin  : request and operands, sampled only on the accepting edge in IDLE
//   busy, done        : high in RUN/DONE; one-cycle pulse when results become valid
//   diff, bout, ovf, zero : registered results, held until the next operation completes
module serial_sub8
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_next;
    logic [WIDTH-1:0] sa, sb, r, r_next;
    logic [CW-1:0] cnt;
    logic br, a_msb, b_msb, d, bo, last;

    full_sub1 u_cell (
        .x (sa[0]),
        .y (sb[0]),
        .bi(br),
        .d (d),
        .bo(bo)
    );

    assign last   = (cnt == LAST);
    assign r_next = {d, r[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: state_next = start ? RUN : IDLE;
            RUN: begin
                busy       = 1'b1;
                state_next = last ? DONE : RUN;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            r     <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (state == IDLE && start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= bo;
            r   <= r_next;
            cnt <= cnt + 1'b1;
            // Final step: d is the result MSB, bo the borrow out of the whole word.
            if (last) begin
                diff <= r_next;
                bout <= bo;
                ovf  <= (a_msb ^ b_msb) & (d ^ a_msb);
                zero <= ~|r_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_sub8.sv
// tb_serial_sub8: scoreboard bench for serial_sub8 with directed and randomised vectors.
module tb_serial_sub8;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        logic       z;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_i = '0;
    logic [7:0] b_i = '0;
    logic       bin_i = 1'b0;
    logic       busy, done, bout, ovf, zero;
    logic [7:0] diff;

    int   checks = 0;
    int   failures = 0;
    res_t q[$];
    logic [7:0] prev_diff = '0;

    serial_sub8 #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a_i),
        .b    (b_i),
        .bin  (bin_i),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf),
        .zero (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [8:0] t;
        res_t e;
        t    = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        e.d  = t[7:0];
        e.bo = t[8];
        e.ov = (a[7] != b[7]) && (t[7] != a[7]);
        e.z  = (t[7:0] == 8'd0);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%0h expected=none", {diff, bout, ovf, zero});
            end else begin
                res_t e;
                e = q.pop_front();
                check("result", {diff, bout, ovf, zero}, {e.d, e.bo, e.ov, e.z});
            end
        end
    end

    // Issue one request; returns just after the accepting edge with start released.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi, input res_t e);
        @(negedge clk);
        a_i   = a;
        b_i   = b;
        bin_i = bi;
        start = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_at_accept", busy, 1);
        check("diff_held_at_accept", diff, prev_diff);
        prev_diff = e.d;
        a_i   = 8'($urandom);
        b_i   = 8'($urandom);
        bin_i = 1'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 30);
        check("done_seen", done, 1);
        @(negedge clk);
        check("idle_after_done", {busy, done}, 0);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi, input res_t e);
        int n;
        start_op(a, b, bi, e);
        wait_done(n);
        check("latency", n, 9);
    endtask

    initial begin
        int n;
        int seen;
        int k;
        logic pb;
        #12;
        check("reset_outputs", {busy, done, diff, bout, ovf, zero}, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(8'hA0, 8'hA0, 1'b0, '{d: 8'h00, bo: 1'b0, ov: 1'b0, z: 1'b1});
        do_op(8'h58, 8'hF4, 1'b0, '{d: 8'h64, bo: 1'b1, ov: 1'b0, z: 1'b0});
        do_op(8'h3D, 8'h0F, 1'b1, '{d: 8'h2D, bo: 1'b0, ov: 1'b0, z: 1'b0});
        do_op(8'h80, 8'h01, 1'b0, '{d: 8'h7F, bo: 1'b0, ov: 1'b1, z: 1'b0});
        // 127 - (-1) = 128 does not fit in signed 8 bits.
        do_op(8'h7F, 8'hFF, 1'b0, '{d: 8'h80, bo: 1'b1, ov: 1'b1, z: 1'b0});

        // A start pulse while busy must be ignored.
        start_op(8'h12, 8'h05, 1'b0, '{d: 8'h0D, bo: 1'b0, ov: 1'b0, z: 1'b0});
        repeat (2) @(posedge clk);
        #1;
        a_i   = 8'h11;
        b_i   = 8'h22;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        repeat (12) @(negedge clk);
        check("no_second_op", busy, 0);

        // Reset asserted mid-RUN clears everything at once and discards the op.
        start_op(8'h40, 8'h10, 1'b0, '{d: 8'h30, bo: 1'b0, ov: 1'b0, z: 1'b0});
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {busy, done, diff, bout, ovf, zero}, 0);
        q.delete();
        prev_diff = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no_done_after_reset", seen, 0);

        // start held high: second accept lands exactly ten edges after the first.
        @(negedge clk);
        a_i   = 8'h01;
        b_i   = 8'h02;
        bin_i = 1'b0;
        start = 1'b1;
        q.push_back('{d: 8'hFF, bo: 1'b1, ov: 1'b0, z: 1'b0});
        @(posedge clk);
        #1;
        a_i = 8'hC8;
        b_i = 8'h48;
        q.push_back('{d: 8'h80, bo: 1'b0, ov: 1'b0, z: 1'b0});
        pb = busy;
        k  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (busy && !pb) begin
                k = i;
                break;
            end
            pb = busy;
        end
        start = 1'b0;
        check("second_accept_edge", k, 10);
        prev_diff = 8'h80;
        wait_done(n);
        check("latency_b2b", n, 9);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rbi;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbi = 1'($urandom);
            if (i < 4) begin
                ra  = (i < 2) ? 8'h00 : 8'hFF;
                rb  = (i[0]) ? 8'hFF : 8'h00;
                rbi = 1'b1;
            end
            do_op(ra, rb, rbi, model(ra, rb, rbi));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
